alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Parses ALU command frames from the UART RX byte stream, loads operands and function code into
//  the ALU, pulses its enable, captures the 16-bit result and returns it to UART TX as two bytes
//  (LSB first). Sits in the system-control layer between UART RX/TX and the ALU datapath.
//  Also drives the ALU clock-gate enable.
// PARAMETERS
//  DATA_WIDTH   8      UART byte width; ALU operand width
//  CMD_OPER     8'hCC  frame opcode: A, B, FUN follow
//  CMD_NO_OPER  8'hDD  frame opcode: FUN follows; reuse last A/B
//  TIMEOUT      16     max cycles from ALU_EN pulse to ALU_OUT_VLD before abort (>=2)
// PORTS
//  CLK          in   1     system clock, rising edge
//  RST          in   1     asynchronous reset, active-low
//  RX_P_DATA    in   8     received byte
//  RX_D_VLD     in   1     RX_P_DATA valid, one-cycle pulse per byte
//  ALU_A        out  8     operand A (registered)
//  ALU_B        out  8     operand B (registered)
//  ALU_FUN      out  4     ALU function code = RX byte [3:0] (registered)
//  ALU_EN       out  1     one-cycle ALU start pulse
//  CLK_GATE_EN  out  1     ALU clock enable
//  ALU_OUT      in   16    ALU result
//  ALU_OUT_VLD  in   1     ALU_OUT valid, one-cycle pulse
//  TX_P_DATA    out  8     byte to transmit (registered)
//  TX_D_VLD     out  1     one-cycle transmit request
//  TX_BUSY      in   1     transmitter busy; rises 1 cycle after accepted TX_D_VLD
//  BUSY         out  1     high in any state other than IDLE
//  ERR          out  1     one-cycle pulse: unknown opcode or ALU timeout
// BEHAVIOUR
//  Reset (RST=0, async): state=IDLE; ALU_A/B=0, ALU_FUN=0, result reg=0, TX_P_DATA=0;
//   ALU_EN, CLK_GATE_EN, TX_D_VLD, BUSY, ERR=0. Reset mid-frame discards frame; no TX.
//  States: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND_LSB, SEND_MSB, WAIT_TX.
//  IDLE: RX_D_VLD & byte==CMD_OPER -> GET_A; ==CMD_NO_OPER -> GET_FUN; other byte -> ERR pulse
//   next cycle, stay IDLE.
//  GET_A/GET_B: on RX_D_VLD latch byte into ALU_A/ALU_B, advance. No intra-frame timeout.
//  GET_FUN: on RX_D_VLD latch byte[3:0] into ALU_FUN, -> ALU_RUN; CLK_GATE_EN=1 from next cycle.
//  ALU_RUN: exactly one cycle; ALU_EN=1; -> WAIT_RES; timeout counter cleared.
//  WAIT_RES: CLK_GATE_EN=1; ALU_OUT_VLD -> capture ALU_OUT, -> SEND_LSB. Counter increments
//   each cycle; reaching TIMEOUT without VLD -> ERR pulse, -> IDLE, no TX. VLD on the same cycle
//   the count reaches TIMEOUT wins (result captured).
//  CLK_GATE_EN falls the cycle after leaving WAIT_RES.
//  SEND_LSB/SEND_MSB: when TX_BUSY=0 drive TX_P_DATA=result[7:0]/[15:8], TX_D_VLD=1 one
//   cycle, -> WAIT_TX. TX_BUSY=1 -> hold, no pulse.
//  WAIT_TX: ignore TX_BUSY on first cycle (guard), then wait TX_BUSY=0; after LSB -> SEND_MSB,
//   after MSB -> IDLE.
//  ALU_OUT_VLD outside WAIT_RES ignored. RX_D_VLD in ALU_RUN..WAIT_TX dropped silently (no ERR).
//  ALU_A/B/FUN hold value between frames; CMD_NO_OPER reuses them (A=B=0 after reset).
//  Latency: FUN byte VLD at cycle n -> ALU_EN at n+1; VLD result at m -> TX_D_VLD at m+1 if idle.
// TESTING
//  CC,05,03,00 -> ALU_A=05,B=03,FUN=0; ALU_EN 1 cycle after FUN; ALU_OUT=0008 VLD -> TX 08, 00.
//  Then DD,01 -> ALU_A=05,B=03 unchanged, FUN=1; ALU_OUT=FFFE -> TX FE then FF.
//  Hold TX_BUSY=1 for 20 cycles at SEND_LSB -> TX_D_VLD stays 0; pulses 1 cycle after release.
//  No ALU_OUT_VLD after ALU_EN -> ERR pulse at cycle TIMEOUT(16); BUSY=0; no TX_D_VLD.
//  Byte 55 in IDLE -> ERR 1-cycle pulse, stays IDLE; following CC frame handled normally.
//  RST low in WAIT_RES -> all outputs 0 immediately; later VLD ignored; next frame works.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command-frame sequencer between UART RX/TX and the ALU: parses CC/DD frames, launches the ALU,
// waits (bounded) for its result and streams the 16-bit result back LSB first.
module alu_cmd_sequencer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] CMD_OPER    = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] CMD_NO_OPER = 8'hDD,
    parameter int                    TIMEOUT     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_WIDTH-1:0]   rx_p_data_i,
    input  logic                    rx_d_vld_i,
    output logic [DATA_WIDTH-1:0]   alu_a_o,
    output logic [DATA_WIDTH-1:0]   alu_b_o,
    output logic [3:0]              alu_fun_o,
    output logic                    alu_en_o,
    output logic                    clk_gate_en_o,
    input  logic [2*DATA_WIDTH-1:0] alu_out_i,
    input  logic                    alu_out_vld_i,
    output logic [DATA_WIDTH-1:0]   tx_p_data_o,
    output logic                    tx_d_vld_o,
    input  logic                    tx_busy_i,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND_LSB, SEND_MSB, WAIT_TX
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
    logic [3:0]              fun_q, fun_d;
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    tx_vld_q, tx_vld_d, err_q, err_d;
    logic                    guard_q, guard_d, msb_q, msb_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            fun_q     <= '0;
            res_q     <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            tx_vld_q  <= 1'b0;
            err_q     <= 1'b0;
            guard_q   <= 1'b0;
            msb_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            fun_q     <= fun_d;
            res_q     <= res_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            tx_vld_q  <= tx_vld_d;
            err_q     <= err_d;
            guard_q   <= guard_d;
            msb_q     <= msb_d;
        end
    end

    // cnt_q equals the number of cycles since the ALU_EN cycle; the last VLD-accepting cycle
    // is TIMEOUT-1, so ERR lands exactly TIMEOUT cycles after ALU_EN.
    // TX_D_VLD is registered: the transmit decision is taken one cycle ahead, using the
    // current TX_BUSY, so the pulse appears on the first cycle of (or within) SEND_x.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        fun_d     = fun_q;
        res_d     = res_q;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        tx_vld_d  = 1'b0;
        err_d     = 1'b0;
        guard_d   = guard_q;
        msb_d     = msb_q;
        case (state_q)
            IDLE: begin
                if (rx_d_vld_i) begin
                    if (rx_p_data_i == CMD_OPER)         state_d = GET_A;
                    else if (rx_p_data_i == CMD_NO_OPER) state_d = GET_FUN;
                    else                                 err_d   = 1'b1;
                end
            end
            GET_A: begin
                if (rx_d_vld_i) begin
                    a_d     = rx_p_data_i;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (rx_d_vld_i) begin
                    b_d     = rx_p_data_i;
                    state_d = GET_FUN;
                end
            end
            GET_FUN: begin
                if (rx_d_vld_i) begin
                    fun_d   = rx_p_data_i[3:0];
                    cnt_d   = '0;
                    state_d = ALU_RUN;
                end
            end
            ALU_RUN: begin
                cnt_d   = CW'(1);
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (alu_out_vld_i) begin
                    res_d   = alu_out_i;
                    state_d = SEND_LSB;
                    if (!tx_busy_i) begin
                        tx_vld_d  = 1'b1;
                        tx_data_d = alu_out_i[DATA_WIDTH-1:0];
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEND_LSB, SEND_MSB: begin
                if (tx_vld_q) begin
                    guard_d = 1'b1;
                    msb_d   = (state_q == SEND_MSB);
                    state_d = WAIT_TX;
                end else if (!tx_busy_i) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = (state_q == SEND_MSB) ? res_q[2*DATA_WIDTH-1:DATA_WIDTH]
                                                      : res_q[DATA_WIDTH-1:0];
                end
            end
            WAIT_TX: begin
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!tx_busy_i) begin
                    if (msb_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = SEND_MSB;
                        tx_vld_d  = 1'b1;
                        tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_fun_o     = fun_q;
    assign alu_en_o      = (state_q == ALU_RUN);
    assign clk_gate_en_o = (state_q == ALU_RUN) || (state_q == WAIT_RES);
    assign tx_p_data_o   = tx_data_q;
    assign tx_d_vld_o    = tx_vld_q;
    assign busy_o        = (state_q != IDLE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomized frame-level bench for alu_cmd_sequencer; expectations come from a
// frame model (last A/B/FUN, result delay, transmitter busy profile) built from the cycle rules.
module tb_alu_cmd_sequencer;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_vld = 1'b0;
    logic [7:0]  alu_a, alu_b, tx_data;
    logic [3:0]  alu_fun;
    logic        alu_en, gate_en, tx_vld, busy, err;
    logic [15:0] alu_out = 16'h0000;
    logic        alu_vld = 1'b0;
    logic        tx_busy = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int frame_no = 0;
    logic [7:0] a_m = 8'h00, b_m = 8'h00;
    logic [3:0] fun_m = 4'h0;

    alu_cmd_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_p_data_i(rx_data), .rx_d_vld_i(rx_vld),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_fun_o(alu_fun),
        .alu_en_o(alu_en), .clk_gate_en_o(gate_en),
        .alu_out_i(alu_out), .alu_out_vld_i(alu_vld),
        .tx_p_data_o(tx_data), .tx_d_vld_o(tx_vld), .tx_busy_i(tx_busy),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        step();
        rx_vld  = 1'b0;
        rx_data = 8'($urandom);
    endtask

    // delay = cycles after ALU_EN at which ALU_OUT_VLD is given (0 = never -> timeout);
    // l1/l2 = TX_BUSY high time after each byte; hold = cycles TX_BUSY is held at SEND_LSB.
    task automatic run_frame(input bit use_dd, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] f, input int delay, input logic [15:0] res,
                             input int l1, input int l2, input int hold, input bit noise);
        int kmax;
        if (!use_dd) begin
            a_m = a;
            b_m = b;
        end
        fun_m = f[3:0];
        send_byte(use_dd ? 8'hDD : 8'hCC);
        check("opcode_busy", 16'(busy), 16'd1);
        check("opcode_no_err", 16'(err), 16'd0);
        if (!use_dd) begin
            if (noise) begin
                alu_vld = 1'b1;
                alu_out = 16'($urandom);
            end
            send_byte(a);
            alu_vld = 1'b0;
            send_byte(b);
        end
        send_byte(f);
        check("alu_en_after_fun", 16'(alu_en), 16'd1);
        check("gate_on_run", 16'(gate_en), 16'd1);
        check("alu_a", 16'(alu_a), 16'(a_m));
        check("alu_b", 16'(alu_b), 16'(b_m));
        check("alu_fun", 16'(alu_fun), 16'(fun_m));
        if (hold > 0) tx_busy = 1'b1;
        kmax = (delay == 0) ? TIMEOUT - 1 : delay;
        for (int k = 1; k <= kmax; k++) begin
            step();
            check("alu_en_single", 16'(alu_en), 16'd0);
            check("gate_wait", 16'(gate_en), 16'd1);
            check("no_tx_in_wait", 16'(tx_vld), 16'd0);
            check("no_err_in_wait", 16'(err), 16'd0);
            if (noise) begin
                rx_vld  = 1'($urandom);
                rx_data = 8'($urandom);
            end
            if (k == delay) begin
                alu_vld = 1'b1;
                alu_out = res;
            end
        end
        rx_vld = 1'b0;
        step();
        alu_vld = 1'b0;
        if (delay == 0) begin
            check("timeout_err", 16'(err), 16'd1);
            check("timeout_idle", 16'(busy), 16'd0);
            check("timeout_gate_off", 16'(gate_en), 16'd0);
            check("timeout_no_tx", 16'(tx_vld), 16'd0);
            step();
            check("timeout_err_pulse", 16'(err), 16'd0);
            check("timeout_no_tx2", 16'(tx_vld), 16'd0);
            $display("frame %0d: op=%s fun=%h timeout", frame_no, use_dd ? "DD" : "CC", fun_m);
            frame_no++;
            return;
        end
        check("gate_off", 16'(gate_en), 16'd0);
        check("no_err_result", 16'(err), 16'd0);
        for (int i = 0; i < hold; i++) begin
            check("hold_no_tx", 16'(tx_vld), 16'd0);
            step();
        end
        if (hold > 0) begin
            tx_busy = 1'b0;
            check("release_no_tx", 16'(tx_vld), 16'd0);
            step();
        end
        check("tx_lsb_vld", 16'(tx_vld), 16'd1);
        check("tx_lsb_data", 16'(tx_data), 16'(res[7:0]));
        step();
        tx_busy = 1'b1;
        check("tx_lsb_pulse", 16'(tx_vld), 16'd0);
        for (int i = 1; i < l1; i++) begin
            step();
            check("tx_wait_lsb", 16'(tx_vld), 16'd0);
        end
        step();
        tx_busy = 1'b0;
        check("tx_wait_lsb_end", 16'(tx_vld), 16'd0);
        step();
        check("tx_msb_vld", 16'(tx_vld), 16'd1);
        check("tx_msb_data", 16'(tx_data), 16'(res[15:8]));
        step();
        tx_busy = 1'b1;
        check("tx_msb_pulse", 16'(tx_vld), 16'd0);
        for (int i = 1; i < l2; i++) begin
            step();
            check("tx_wait_msb", 16'(tx_vld), 16'd0);
        end
        step();
        tx_busy = 1'b0;
        check("busy_wait_tx", 16'(busy), 16'd1);
        step();
        check("idle_after_msb", 16'(busy), 16'd0);
        check("no_tx_after_msb", 16'(tx_vld), 16'd0);
        $display("frame %0d: op=%s a=%h b=%h fun=%h res=%h delay=%0d", frame_no,
                 use_dd ? "DD" : "CC", a_m, b_m, fun_m, res, delay);
        frame_no++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, 16'(alu_a), 16'd0);
        check({tag, "_b"}, 16'(alu_b), 16'd0);
        check({tag, "_fun"}, 16'(alu_fun), 16'd0);
        check({tag, "_en"}, 16'(alu_en), 16'd0);
        check({tag, "_gate"}, 16'(gate_en), 16'd0);
        check({tag, "_txd"}, 16'(tx_data), 16'd0);
        check({tag, "_txv"}, 16'(tx_vld), 16'd0);
        check({tag, "_busy"}, 16'(busy), 16'd0);
        check({tag, "_err"}, 16'(err), 16'd0);
    endtask

    initial begin
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        run_frame(1'b0, 8'h05, 8'h03, 8'h00, 3, 16'h0008, 2, 1, 0, 1'b0);
        run_frame(1'b1, 8'h00, 8'h00, 8'h01, 5, 16'hFFFE, 1, 3, 0, 1'b0);
        run_frame(1'b0, 8'hA7, 8'h3C, 8'h02, 2, 16'h1234, 1, 1, 20, 1'b0);
        run_frame(1'b1, 8'h00, 8'h00, 8'h03, 0, 16'h0000, 1, 1, 0, 1'b1);
        run_frame(1'b1, 8'h00, 8'h00, 8'h04, TIMEOUT - 1, 16'hBEEF, 2, 2, 0, 1'b0);
        run_frame(1'b0, 8'h11, 8'h22, 8'h05, 1, 16'h55AA, 1, 1, 0, 1'b1);

        send_byte(8'h55);
        check("bad_opcode_err", 16'(err), 16'd1);
        check("bad_opcode_idle", 16'(busy), 16'd0);
        step();
        check("bad_opcode_pulse", 16'(err), 16'd0);
        check("bad_opcode_still_idle", 16'(busy), 16'd0);
        $display("frame %0d: byte 55 rejected in IDLE", frame_no);
        frame_no++;
        run_frame(1'b0, 8'h9A, 8'h0F, 8'h06, 4, 16'h0F0F, 1, 2, 0, 1'b0);

        send_byte(8'hCC);
        send_byte(8'h77);
        send_byte(8'h88);
        send_byte(8'h07);
        step();
        step();
        check("pre_reset_gate", 16'(gate_en), 16'd1);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        a_m   = 8'h00;
        b_m   = 8'h00;
        fun_m = 4'h0;
        rst_n   = 1'b1;
        alu_vld = 1'b1;
        alu_out = 16'hCAFE;
        step();
        alu_vld = 1'b0;
        check("post_reset_idle", 16'(busy), 16'd0);
        step();
        check("post_reset_no_tx", 16'(tx_vld), 16'd0);
        check("post_reset_idle2", 16'(busy), 16'd0);
        $display("frame %0d: reset during WAIT_RES, frame discarded", frame_no);
        frame_no++;
        run_frame(1'b1, 8'h00, 8'h00, 8'h08, 2, 16'h4321, 1, 1, 0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            bit   dd;
            int   dly;
            dd  = (n > 0) && ($urandom_range(0, 2) == 0);
            dly = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TIMEOUT - 1));
            run_frame(dd, 8'($urandom), 8'($urandom), 8'($urandom), dly, 16'($urandom),
                      int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                      1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
